// File: rtl/node_port_rx_if.sv
// Flit type and the point-to-point node_port link between routers.
// Upstream drives flit/enable; the receiver answers with ack.
package node_port_pkg;
  typedef logic [15:0] flit_t;
endpackage

interface node_port;
  import node_port_pkg::*;
  flit_t flit;
  logic  enable;
  logic  ack;

  modport up   (output flit, output enable, input ack);
  modport down (input flit, input enable, output ack);
endinterface

// File: rtl/node_port_rx.sv
// Router input port: accepts flits from the node_port link into a small FIFO
// and presents them as a first-word-fall-through valid/ready stream.
module node_port_rx
  import node_port_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  node_port.down                 in,
  output flit_t                  out_flit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       rx_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  flit_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Ack looks only at enable and registered state; a pop never frees a slot
  // in the same cycle, so out_ready has no path to ack.
  assign in.ack    = in.enable & ~reset & (occupancy != FULL);
  assign push      = in.ack;
  assign out_valid = (occupancy != '0);
  assign pop       = out_valid & out_ready;
  assign out_flit  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      rx_count  <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        rx_count <= rx_count + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Storage is not reset; stale entries are never visible because out_valid
  // is derived from occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in.flit;
    end
  end

endmodule

// File: tb/tb_node_port_rx.sv
// Randomized and directed bench for node_port_rx, checked against a queue model.
module tb_node_port_rx;
  import node_port_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               out_ready;
  flit_t              out_flit;
  logic               out_valid;
  logic [2:0]         occupancy;
  logic [CNT_W-1:0]   rx_count;

  node_port link ();

  node_port_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (link.down),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .rx_count  (rx_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit acked;

  // Reference model: a queue of accepted flits and a wrapping accept count.
  flit_t          exp_q[$];
  int unsigned    exp_rx = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor / scoreboard: compares at the falling edge, then advances the model
  // by what the rising edge is about to do.
  initial begin : monitor
    bit exp_ack;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_ack = link.enable && !reset && (exp_q.size() < DEPTH);
      chk("ack", int'(link.ack), int'(exp_ack));
      chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
      chk("occupancy", int'(occupancy), exp_q.size());
      chk("rx_count", int'(rx_count), int'(exp_rx % (1 << CNT_W)));
      if (out_valid && exp_q.size() != 0)
        chk("out_flit", int'(out_flit), int'(exp_q[0]));
      if (reset) begin
        exp_q.delete();
        exp_rx = 0;
      end else begin
        if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (exp_ack) begin
          exp_q.push_back(link.flit);
          exp_rx++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    acked = link.enable && link.ack;
    @(posedge clk);
    #1;
  endtask

  // Offer one flit and hold it until accepted; enable is left high so
  // consecutive sends run back-to-back.
  task automatic send(input flit_t f);
    int n = 0;
    link.flit   = f;
    link.enable = 1'b1;
    do begin
      tick();
      n++;
    end while (!acked && n < 50);
    if (!acked) chk("send_timeout", 0, 1);
  endtask

  initial begin
    reset       = 1'b1;
    link.enable = 1'b1;
    link.flit   = 16'h1111;
    out_ready   = 1'b0;
    @(posedge clk);
    #1;
    tick();
    tick();
    reset       = 1'b0;
    link.enable = 1'b0;
    tick();

    // single flit, then fill to full with E held off
    send(16'h00A0);
    link.enable = 1'b0;
    tick();
    send(16'h00B0);
    send(16'h00C0);
    send(16'h00D0);
    link.flit = 16'h00E0;
    tick();
    tick();
    chk("e_held_off", int'(acked), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("e_accepted_after_pop", int'(acked), 1);
    link.enable = 1'b0;
    out_ready   = 1'b1;
    repeat (6) tick();

    // streaming with wrap-around
    for (int i = 0; i < 10; i++) begin
      int n = 0;
      link.flit   = flit_t'(16'h0100 + i);
      link.enable = 1'b1;
      tick();
      chk("stream_first_offer", int'(acked), 1);
      while (!acked && n < 10) begin tick(); n++; end
    end
    link.enable = 1'b0;
    tick();
    tick();

    // reset in the middle of a held transfer
    out_ready = 1'b0;
    send(16'h0201);
    send(16'h0202);
    send(16'h0203);
    link.flit = 16'h0204;
    reset     = 1'b1;
    tick();
    chk("ack_in_reset", int'(acked), 0);
    reset = 1'b0;
    link.enable = 1'b0;
    tick();
    send(16'h0205);
    link.enable = 1'b0;
    out_ready   = 1'b1;
    repeat (3) tick();

    // randomized traffic obeying the hold-until-ack rule
    for (int c = 0; c < 2000; c++) begin
      if (!link.enable || acked) begin
        link.enable = ($urandom_range(0, 3) != 0);
        link.flit   = flit_t'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset       = 1'b0;
    link.enable = 1'b0;
    out_ready   = 1'b1;
    repeat (DEPTH + 2) tick();
    chk("drained", int'(occupancy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/node_port_rx.md
# node_port_rx

Receiving end of the inter-node `node_port` link. It terminates the `down` modport, accepts flits offered by the upstream node's `up` side, and answers with `ack` backpressure. Accepted flits go into a small FIFO, and the FIFO presents them to local router logic as a first-word-fall-through valid/ready stream. One instance sits on every router input port.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries. Must be a power of 2 and at least 2.
- `CNT_W`, default 16: width of the received-flit counter.

Ports:
- `clk`, input, 1: single clock; every register is clocked on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in`, interface, `node_port.down`: upstream link. `in.flit` (`flit_t`) and `in.enable` are inputs; `in.ack` is the output.
- `out_flit`, output, `flit_t`: head-of-FIFO flit.
- `out_valid`, output, 1: FIFO is non-empty, so `out_flit` is meaningful.
- `out_ready`, input, 1: router consumes the head flit this cycle.
- `occupancy`, output, `$clog2(DEPTH)+1`: number of stored flits, 0..`DEPTH`.
- `rx_count`, output, `CNT_W`: total flits accepted since reset; wraps.

## Operation
Link protocol:
- Upstream raises `enable` with `flit`. It holds both stable until it sees `ack`=1.
- A transfer happens in every cycle where `enable`=1 and `ack`=1.
- `ack` = `enable` AND (`occupancy` < `DEPTH`). It is combinational from `enable` and registered state only, so there is no path from `out_ready` to `ack`.
- `ack` is never 1 while `enable`=0.
- Back-to-back transfers at one flit per cycle are legal.

Storage:
- Circular buffer with `wr_ptr` and `rd_ptr`, each `$clog2(DEPTH)` bits, wrapping naturally modulo `DEPTH`.
- A separate `occupancy` register, so full and empty are unambiguous.

Push and pop:
- Push (transfer): write `mem[wr_ptr]`, then `wr_ptr`++, `rx_count`++. `rx_count` wraps from 2^`CNT_W`-1 to 0.
- Pop (`out_valid` AND `out_ready`): `rd_ptr`++.
- `occupancy`' = `occupancy` + push − pop. Simultaneous push and pop leaves `occupancy` unchanged.

Output stream:
- `out_valid` = (`occupancy` != 0).
- `out_flit` = `mem[rd_ptr]`. It is don't-care while `out_valid`=0.

Boundary conditions:
- Full: `ack`=0 even if a pop happens in the same cycle. There is no full-bypass; the flit is accepted on the next cycle.
- Empty: `out_ready` is ignored and the pointers do not move.
- Empty with a push: there is no combinational pass-through. The flit appears at the output one cycle later.
- `out_ready`=1 with `out_valid`=0 is legal and has no effect.

Reset:
- `reset` clears the pointers, `occupancy`, and `rx_count` to 0.
- FIFO contents are discarded; `mem` is not cleared.
- Reset in the middle of a transfer discards it: `ack`=0 during the reset cycle, so no handshake completes.

## Timing
- Reset values: `occupancy`=0, `out_valid`=0, `rx_count`=0, `in.ack`=0. `out_flit` is don't-care.
- Latency: a flit accepted in cycle N gives `out_valid`=1 and `out_flit` equal to that flit in cycle N+1.
- Throughput: 1 flit/cycle sustained while `out_ready`=1.
- `ack` recovery: pop in cycle N while full, so `occupancy`=`DEPTH`−1 in N+1 and `ack`=`enable` in N+1.
- Registered outputs: `occupancy` and `rx_count` are registered. `out_valid` and `out_flit` are decoded from registers.
- `ack` is combinational from `enable` only. There is one gate level from upstream `enable` to `ack`.

## Test plan
- Reset then idle: hold `reset` for 2 cycles with `enable`=1. Required: `ack`=0, `out_valid`=0, `occupancy`=0, `rx_count`=0 throughout.
- Single flit: `enable`=1 with flit `A` in cycle 1 and `out_ready`=0. Required: `ack`=1 in cycle 1; `out_valid`=1, `out_flit`=`A`, `occupancy`=1, `rx_count`=1 in cycle 2.
- Fill to full (`DEPTH`=4) with `out_ready`=0: offer `A`,`B`,`C`,`D`,`E` back-to-back. Required: `ack`=1 for `A`–`D`; `ack`=0 while `E` is held; `occupancy`=4.
- Drain while full: from the full state, set `out_ready`=1 for 1 cycle. Required: `A` is popped; `ack`=1 for `E` in the next cycle; final order on `out_flit` is `B`,`C`,`D`,`E`.
- Streaming wrap-around: 10 flits with `enable`=1 and `out_ready`=1 every cycle. Required:
  - every flit is acked on first offer;
  - outputs appear in order with 1-cycle latency;
  - `occupancy` stays at 1;
  - `rx_count`=10;
  - pointers wrap twice with no corruption.
- Reset mid-stream: `occupancy`=3, then assert `reset` for 1 cycle while `enable`=1. Required: `ack`=0 in the reset cycle and `occupancy`=0 afterwards. The next accepted flit is the first output and `rx_count`=1.
